sd_spi_cmd_engine: RTL and testbench
====================================

Name: sd_spi_cmd_engine

Overview:
Parametrised SPI-mode SD card command engine. It is the successor to the fixed 48-bit SD command shifter.
- Generates SCLK from the system clock with a programmable divider.
- Performs the power-up dummy-clock sequence.
- Shifts out a 48-bit command, polls for the R1 start byte and reads a variable-length response (R1/R3/R7).
- Reports the response to the host controller through a valid/ready handshake.

Parameters:
CLK_DIV, 32, system clocks per SCLK half-period (>=2)
INIT_CLOCKS, 80, dummy SCLK cycles with cs_n high after reset (>=74)
NCR_MAX, 8, max response-poll bytes before timeout
RESP_MAX_BYTES, 5, max response bytes (response width = 8*RESP_MAX_BYTES)
GAP_CLOCKS, 8, trailing SCLK cycles with cs_n low after response

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  host presents command
cmd_ready  out  1  engine idle and initialised; accepts command
cmd  in  48  command frame incl. CRC, sent MSB first
resp_len  in  3  response bytes incl. R1 (1..RESP_MAX_BYTES), sampled with cmd
resp_valid  out  1  one-cycle pulse, resp/timeout valid
resp  out  8*RESP_MAX_BYTES  response, right-justified, upper bytes zero
timeout  out  1  qualified by resp_valid; no start byte within NCR_MAX bytes
init_done  out  1  dummy-clock sequence complete (sticky until rst)
cs_n  out  1  card select, active-low
sclk  out  1  SPI clock, idle low
mosi  out  1  SPI data out
miso  in  1  SPI data in

Behaviour:
- Reset values: cs_n=1, sclk=0, mosi=1, cmd_ready=0, resp_valid=0, timeout=0, resp=0, init_done=0. State = INIT.
- SPI mode 0:
  - mosi changes only on the SCLK falling edge, or at phase start while sclk is low.
  - miso is sampled in the system cycle that drives sclk 0->1.
  - sclk toggles once every CLK_DIV clk cycles while the engine is clocking; it stays low in IDLE.
- States:
  - INIT: cs_n=1, mosi=1, INIT_CLOCKS full SCLK cycles. Then init_done=1 -> IDLE.
  - IDLE: cmd_ready=1.
    - On cmd_valid&cmd_ready: latch cmd and resp_len. A resp_len of 0 is treated as 1; values >RESP_MAX_BYTES are clamped.
    - cmd_ready drops the next cycle. Next state SEND.
  - SEND: cs_n=0, with cmd[47] on mosi at least one half-period before the first rising edge. 48 SCLK cycles MSB first -> POLL.
  - POLL: mosi=1; clock bytes of 8 bits.
    - A byte with bit7=0 is the R1 and is stored; go to READ, or to GAP if resp_len=1.
    - After NCR_MAX bytes with none found: set timeout=1, resp=0xFF, -> GAP.
  - READ: resp_len-1 further bytes, MSB first, shifted into resp -> GAP.
  - GAP: mosi=1, cs_n=0, GAP_CLOCKS SCLK cycles.
  - DONE: cs_n=1; resp_valid=1 for exactly one clk -> IDLE.
- Response packing: the first byte lands in resp[8*resp_len-1 -: 8]; the last byte is in resp[7:0]; bytes above are zero. resp and timeout hold until the next accept.
- Handshake rules:
  - cmd and resp_len are ignored whenever cmd_ready=0.
  - cmd_valid held high issues back-to-back commands; the earliest next accept is the cycle after resp_valid.
- rst mid-operation: the next cycle shows reset values regardless of state, and INIT runs again, with init_done cleared.
- Counters must never wrap silently:
  - SCLK divider width is clog2(CLK_DIV).
  - Bit counter width is 6.
  - Byte counter width is clog2(max(NCR_MAX, RESP_MAX_BYTES)+1).

Decomposition:
- Package sd_spi_pkg: state enum (INIT, IDLE, SEND, POLL, READ, GAP, DONE), SD_CMD_W=48, SD_START_BIT_POS=7, SD_IDLE_BYTE=8'hFF.
- Sub-module sd_spi_clkgen: divider with enable input. It produces sclk plus one-cycle rise/fall strobes, and holds sclk low when disabled.
- The main FSM consumes these strobes only.

Test Plan:
- Init: CLK_DIV=2, release rst -> exactly 80 sclk rising edges with cs_n=1, mosi=1. Then init_done=1 and cmd_ready=1; sclk stays low afterwards.
- CMD0: cmd=48'h400000000095, resp_len=1; miso gives 0xFF,0xFF then 0x01.
  - mosi bits match cmd MSB first.
  - resp_valid pulses once with resp=40'h01, timeout=0.
  - 8 gap clocks precede the cs_n rise.
- CMD8: cmd=48'h48000001AA87, resp_len=5; miso gives 0xFF then 01 00 00 01 AA -> resp=40'h01000001AA, timeout=0.
- Timeout: miso held 1 -> after 8 poll bytes, resp_valid with timeout=1 and resp=40'hFF; the next command still works.
- Handshake: cmd_valid held high with cmd changed mid-transfer -> the first cmd is sent unchanged; the second is accepted only the cycle after resp_valid. resp_len=0 behaves as 1; resp_len=7 behaves as 5.
- Reset during SEND bit 20 -> next cycle cs_n=1, sclk=0, init_done=0; the full 80-clock init repeats before cmd_ready.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared constants and FSM state encodings for the SPI-mode SD command engine
package sd_spi_pkg;
  localparam int SD_CMD_W = 48;
  localparam int SD_START_BIT_POS = 7;
  localparam logic [7:0] SD_IDLE_BYTE = 8'hFF;
  localparam logic [2:0] ST_INIT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_POLL = 3'd3;
  localparam logic [2:0] ST_READ = 3'd4;
  localparam logic [2:0] ST_GAP  = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;
endpackage

// File: rtl/sd_spi_clkgen.sv
// sd_spi_clkgen: SCLK divider with one-cycle rise/fall strobes; sclk held low while disabled
module sd_spi_clkgen #(
  parameter int CLK_DIV = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt;
  logic tick;
  assign tick = en && (cnt == W'(CLK_DIV - 1));
  assign rise = tick && !sclk;
  assign fall = tick && sclk;
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) sclk <= ~sclk;
    end
  end
endmodule

// File: rtl/sd_spi_cmd_engine.sv
// sd_spi_cmd_engine: SPI-mode SD command engine (init clocks, 48-bit command, R1 poll, response read)
module sd_spi_cmd_engine
  import sd_spi_pkg::*;
#(
  parameter int CLK_DIV        = 32,
  parameter int INIT_CLOCKS    = 80,
  parameter int NCR_MAX        = 8,
  parameter int RESP_MAX_BYTES = 5,
  parameter int GAP_CLOCKS     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [SD_CMD_W-1:0]         cmd,
  input  logic [2:0]                  resp_len,
  output logic                        resp_valid,
  output logic [8*RESP_MAX_BYTES-1:0] resp,
  output logic                        timeout,
  output logic                        init_done,
  output logic                        cs_n,
  output logic                        sclk,
  output logic                        mosi,
  input  logic                        miso
);
  localparam int RW  = 8 * RESP_MAX_BYTES;
  localparam int ICW = $clog2(INIT_CLOCKS + 1);
  localparam int BCW = $clog2((NCR_MAX > RESP_MAX_BYTES ? NCR_MAX : RESP_MAX_BYTES) + 1);
  logic [2:0]          state;
  logic [ICW-1:0]      init_cnt;
  logic [5:0]          bit_cnt;
  logic [BCW-1:0]      byte_cnt;
  logic [2:0]          len;
  logic [SD_CMD_W-1:0] cmd_sr;
  logic [7:0]          sr;
  logic                en, rise, fall;
  assign en         = (state != ST_IDLE) && (state != ST_DONE);
  assign cmd_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_DONE);
  sd_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .sclk (sclk),
    .rise (rise),
    .fall (fall)
  );
  // Every transition happens on a falling strobe so sclk is already low when the divider is disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      cs_n      <= 1'b1;
      mosi      <= 1'b1;
      resp      <= '0;
      timeout   <= 1'b0;
      init_done <= 1'b0;
      init_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      len       <= 3'd1;
      cmd_sr    <= '0;
      sr        <= '0;
    end else begin
      if (rise) sr <= {sr[6:0], miso};
      case (state)
        ST_INIT: if (fall) begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == ICW'(INIT_CLOCKS - 1)) begin
            init_done <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_IDLE: if (cmd_valid) begin
          cmd_sr  <= cmd;
          mosi    <= cmd[SD_CMD_W-1];
          cs_n    <= 1'b0;
          resp    <= '0;
          timeout <= 1'b0;
          bit_cnt <= '0;
          len     <= resp_len == 3'd0 ? 3'd1 :
                     resp_len > 3'(RESP_MAX_BYTES) ? 3'(RESP_MAX_BYTES) : resp_len;
          state   <= ST_SEND;
        end
        ST_SEND: if (fall) begin
          bit_cnt <= bit_cnt + 1'b1;
          cmd_sr  <= cmd_sr << 1;
          mosi    <= cmd_sr[SD_CMD_W-2];
          if (bit_cnt == 6'(SD_CMD_W - 1)) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            mosi     <= 1'b1;
            state    <= ST_POLL;
          end
        end
        ST_POLL: if (fall) begin
          bit_cnt <= bit_cnt == 6'd7 ? 6'd0 : bit_cnt + 1'b1;
          if (bit_cnt == 6'd7) begin
            if (!sr[SD_START_BIT_POS]) begin
              resp     <= RW'(sr);
              byte_cnt <= BCW'(1);
              state    <= len == 3'd1 ? ST_GAP : ST_READ;
            end else if (byte_cnt == BCW'(NCR_MAX - 1)) begin
              timeout <= 1'b1;
              resp    <= RW'(SD_IDLE_BYTE);
              state   <= ST_GAP;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        ST_READ: if (fall) begin
          bit_cnt <= bit_cnt == 6'd7 ? 6'd0 : bit_cnt + 1'b1;
          if (bit_cnt == 6'd7) begin
            resp     <= (resp << 8) | RW'(sr);
            byte_cnt <= byte_cnt + 1'b1;
            if (BCW'(byte_cnt + 1'b1) == BCW'(len)) state <= ST_GAP;
          end
        end
        ST_GAP: if (fall) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 6'(GAP_CLOCKS - 1)) begin
            bit_cnt <= '0;
            cs_n    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// tb_sd_spi_cmd_engine: directed bench with an SD card model and a response scoreboard
module tb_sd_spi_cmd_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [47:0] cmd;
  logic [2:0]  resp_len;
  logic        resp_valid;
  logic [39:0] resp;
  logic        timeout;
  logic        init_done;
  logic        cs_n;
  logic        sclk;
  logic        mosi;
  logic        miso = 1'b1;

  typedef struct {
    logic [47:0] cmd;
    logic [39:0] resp;
    logic        to;
    int          rises;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0, passed = 0, fails = 0;
  int          nrise = 0, init_rises = 0, init_bad = 0, mk;
  int          cyc = 0, accepts = 0, acc_cyc = 0, rv_cyc = 0;
  logic [47:0] rx = '0;
  logic [7:0]  pat[16];
  int          pat_n = 0;

  sd_spi_cmd_engine #(.CLK_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd        (cmd),
    .resp_len   (resp_len),
    .resp_valid (resp_valid),
    .resp       (resp),
    .timeout    (timeout),
    .init_done  (init_done),
    .cs_n       (cs_n),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Card model: captures the command on rising edges, drives response bits on falling edges
  always @(negedge cs_n) nrise = 0;
  always @(posedge cs_n) miso = 1'b1;
  always @(posedge sclk) begin
    if (!cs_n) begin
      if (nrise < 48) rx = {rx[46:0], mosi};
      nrise++;
    end else begin
      init_rises++;
      if (mosi !== 1'b1) init_bad++;
    end
  end
  always @(negedge sclk) begin
    if (!cs_n && nrise >= 48) begin
      mk = nrise - 48;
      miso = (mk / 8 < pat_n) ? pat[mk/8][7-(mk%8)] : 1'b1;
    end
  end

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) begin
      accepts++;
      acc_cyc = cyc;
    end
    if (resp_valid) rv_cyc = cyc;
    cyc++;
  end

  always @(negedge clk) begin
    if (resp_valid) begin
      if (q.size() == 0) chk("spurious_resp_valid", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("resp", resp, mon_e.resp);
        chk("timeout", timeout, mon_e.to);
        chk("cmd_bits", rx, mon_e.cmd);
        chk("sclk_rises", nrise, mon_e.rises);
        chk("cs_n_done", cs_n, 1);
      end
    end
  end

  task automatic set_pat(input logic [63:0] v, input int n);
    pat_n = n;
    for (int i = 0; i < n; i++) pat[i] = v[8*(n-1-i) +: 8];
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("init_done", init_done, 1);
    chk("init_rises", init_rises, 80);
    chk("init_cs_mosi", init_bad, 0);
    chk("init_ready", cmd_ready, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("resp_seen", q.size(), 0);
  endtask

  task automatic issue(input logic [47:0] c, input logic [2:0] l, input logic [39:0] r,
                       input logic t, input int rises);
    int n = 0;
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("ready", cmd_ready, 1);
    q.push_back('{c, r, t, rises});
    cmd = c;
    resp_len = l;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd = ~c;
    resp_len = 3'd3;
    chk("ready_drop", cmd_ready, 0);
    drain();
  endtask

  initial begin
    int n, base;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd = '0;
    resp_len = 3'd1;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 1);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_resp", resp, 0);
    chk("rst_init_done", init_done, 0);
    init_rises = 0;
    init_bad = 0;
    rst = 1'b0;
    wait_init();
    repeat (20) @(negedge clk);
    chk("idle_sclk_low", sclk, 0);
    chk("idle_no_rises", init_rises, 80);

    set_pat(64'hFFFF01, 3);
    issue(48'h400000000095, 3'd1, 40'h01, 1'b0, 80);
    set_pat(64'hFF01000001AA, 6);
    issue(48'h48000001AA87, 3'd5, 40'h01000001AA, 1'b0, 104);
    set_pat(64'h0, 0);
    issue(48'h770000000065, 3'd1, 40'hFF, 1'b1, 120);
    set_pat(64'hFFFF01, 3);
    issue(48'h400000000095, 3'd1, 40'h01, 1'b0, 80);

    // cmd_valid held high across two transactions, cmd changed mid-transfer
    set_pat(64'hFF0102030405, 6);
    q.push_back('{48'h7A0000000075, 40'h01, 1'b0, 72});
    q.push_back('{48'h690000000077, 40'h0102030405, 1'b0, 104});
    base = accepts;
    cmd = 48'h7A0000000075;
    resp_len = 3'd0;
    cmd_valid = 1'b1;
    repeat (60) @(negedge clk);
    cmd = 48'h690000000077;
    resp_len = 3'd7;
    n = 0;
    while (accepts < base + 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", accepts - base, 2);
    chk("b2b_gap", acc_cyc - rv_cyc, 1);
    drain();

    // Reset in the middle of SEND
    set_pat(64'hFF01, 2);
    cmd = 48'h400000000095;
    resp_len = 3'd1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (nrise < 20 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_bit20", nrise, 20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_cs_n", cs_n, 1);
    chk("midrst_sclk", sclk, 0);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_mosi", mosi, 1);
    @(negedge clk);
    init_rises = 0;
    init_bad = 0;
    rst = 1'b0;
    wait_init();
    set_pat(64'hFFFF01, 3);
    issue(48'h400000000095, 3'd1, 40'h01, 1'b0, 80);
    repeat (10) @(negedge clk);
    chk("no_late_resp", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
